quint_seq_arbiter: RTL

Two-requester sequencer for the multiply-by-5 datapath. It computes Y = A * 5^N by iterating a single ×5 step N times, with a sticky overflow flag. It arbitrates round-robin between two requesters using valid/ready handshakes and returns one tagged response at a time. It sits between ALU operand/opcode decode and the ALU result mux.

---
 rtl/alu_pkg.sv | 19 +
 rtl/quint_step.sv | 29 ++
 rtl/quint_seq_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multiply-by-5 ALU path.
// Holds default widths, the sequencer state encoding and signed range limits.
package alu_pkg;

    localparam int W_IN_DEF  = 6;
    localparam int W_ACC_DEF = 9;
    localparam int W_N_DEF   = 3;

    localparam int FIVE    = 5;
    localparam int ACC_MAX = (2 ** (W_ACC_DEF - 1)) - 1;
    localparam int ACC_MIN = -(2 ** (W_ACC_DEF - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/quint_step.sv
// One x5 step: wrapped signed product plus a flag when the exact product leaves the accumulator range.
// Purely combinational, no handshake.
module quint_step
    import alu_pkg::*;
#(
    parameter int W_ACC   = W_ACC_DEF,
    parameter int LIM_MAX = ACC_MAX,
    parameter int LIM_MIN = ACC_MIN
) (
    input  logic signed [W_ACC-1:0] acc,
    output logic signed [W_ACC-1:0] acc_x5,
    output logic                    ovf
);

    localparam int WP = W_ACC + 3;
    localparam logic signed [WP-1:0] P_FIVE = WP'(FIVE);
    localparam logic signed [WP-1:0] P_MAX  = WP'(LIM_MAX);
    localparam logic signed [WP-1:0] P_MIN  = WP'(LIM_MIN);

    logic signed [WP-1:0] acc_ext;
    logic signed [WP-1:0] prod;

    // Three guard bits hold |acc*5| exactly, so the range test is on the true product.
    assign acc_ext = {{3{acc[W_ACC-1]}}, acc};
    assign prod    = acc_ext * P_FIVE;
    assign acc_x5  = prod[W_ACC-1:0];
    assign ovf     = (prod > P_MAX) || (prod < P_MIN);

endmodule

// File: rtl/quint_seq_arbiter.sv
// Round-robin two-requester sequencer computing A*5^N one step per cycle, sticky overflow.
// Response N+1 cycles after accept; held stable until rsp_ready, one idle bubble before next accept.
module quint_seq_arbiter
    import alu_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int W_ACC = W_ACC_DEF,
    parameter int W_N   = W_N_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic signed [W_IN-1:0]  req0_a,
    input  logic [W_N-1:0]          req0_n,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic signed [W_IN-1:0]  req1_a,
    input  logic [W_N-1:0]          req1_n,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic signed [W_ACC-1:0] rsp_y,
    output logic                    rsp_of,
    output logic                    rsp_id
);

    state_t state, nxt;

    logic signed [W_ACC-1:0] acc;
    logic [W_N-1:0]          cnt;
    logic                    id;
    logic                    of;
    logic                    last;

    logic                    gnt0, gnt1, accept;
    logic signed [W_IN-1:0]  sel_a;
    logic [W_N-1:0]          sel_n;
    logic signed [W_ACC-1:0] step_y;
    logic                    step_of;

    quint_step #(
        .W_ACC   (W_ACC),
        .LIM_MAX ((2 ** (W_ACC - 1)) - 1),
        .LIM_MIN (-(2 ** (W_ACC - 1)))
    ) u_step (
        .acc    (acc),
        .acc_x5 (step_y),
        .ovf    (step_of)
    );

    // On a tie the requester not served last wins.
    assign gnt0   = req0_valid && (!req1_valid || last);
    assign gnt1   = req1_valid && (!req0_valid || !last);
    assign accept = req0_ready || req1_ready;
    assign sel_a  = gnt1 ? req1_a : req0_a;
    assign sel_n  = gnt1 ? req1_n : req0_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept)            nxt = (sel_n == '0) ? DONE : RUN;
            RUN:  if (cnt == W_N'(1))    nxt = DONE;
            DONE: if (rsp_ready)         nxt = IDLE;
            default:                     nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) && gnt0;
        req1_ready = (state == IDLE) && gnt1;
        rsp_valid  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            cnt  <= '0;
            id   <= 1'b0;
            of   <= 1'b0;
            last <= 1'b1;
        end else if (state == IDLE && accept) begin
            acc  <= {{(W_ACC - W_IN){sel_a[W_IN-1]}}, sel_a};
            cnt  <= sel_n;
            id   <= gnt1;
            of   <= 1'b0;
            last <= gnt1;
        end else if (state == RUN) begin
            acc <= step_y;
            of  <= of | step_of;
            cnt <= cnt - W_N'(1);
        end
    end

    assign rsp_y  = acc;
    assign rsp_of = of;
    assign rsp_id = id;

endmodule
